dc_token_src_channel: RTL and testbench
=======================================

# dc_token_src_channel

Writer half of the token-based dual-clock channel carrying one AXI channel (AW, AR or W) from the local clock domain into the SoC domain's `*_writetoken_i` / `*_readpointer_o` / payload ports. It accepts payload beats on a local valid/ready handshake and stores them in an 8-slot register buffer. It publishes a one-bit-per-step write token and presents the slot selected by the far side's read pointer. The far side's reader instance consumes the token and returns the pointer; this block handles only the writer domain.

## Interface
- `DATA_WIDTH`, default 32: payload bits per beat, all AXI fields of the channel concatenated.
- `BUFFER_WIDTH`, default 8: token and pointer width; buffer depth equals `BUFFER_WIDTH`. Must be 8 or greater.
- `clk_i` in, 1: writer-domain clock. This block has one clock.
- `rst_ni` in, 1: asynchronous active-low reset.
- `valid_i` in, 1: local beat valid.
- `ready_o` out, 1: buffer not full.
- `data_i` in, DATA_WIDTH: local beat payload.
- `writetoken_o` out, BUFFER_WIDTH: registered Johnson-coded write position, sent to the far domain.
- `readpointer_i` in, BUFFER_WIDTH: Johnson-coded read position from the far domain. Asynchronous to `clk_i`.
- `data_async_o` out, DATA_WIDTH: contents of the buffer slot addressed by the raw `readpointer_i`.
- `fill_o` out, $clog2(BUFFER_WIDTH)+1: occupancy as seen through the synchronized pointer.

## Operation
- **Token encoding.** Tokens and pointers are Johnson counters. The next value is `{tok[BW-2:0], ~tok[BW-1]}`, so exactly one bit changes per step and the cycle length is 2*BW states.
- **Slot index.** `slot(tok)` is the popcount of `tok` when `tok[BW-1]==0`, otherwise the count of zeros in `tok`. This gives 0..BW-1.
- **Write.** On a rising edge with `valid_i && ready_o`:
  - `buf[slot(writetoken_o)] <= data_i`.
  - `writetoken_o` advances one step.
  - In all other cycles the buffer and the token hold.
- **Pointer synchronizer.** `readpointer_i` passes through a 2-flop synchronizer to produce `rp_sync`. The synchronizer length is 3 flops under the configuration macro.
- **Empty / full.**
  - Empty when `writetoken_o == rp_sync`.
  - Full when `writetoken_o == ~rp_sync`, i.e. the write token is BW steps ahead.
  - `ready_o = !full`. It is combinational from registers only and never depends on `valid_i`.
- **Occupancy.** `fill_o = (k(writetoken_o) - k(rp_sync)) mod 2*BW`.
  - `k(tok)` is the Johnson state index: equal to `slot(tok)` when `tok[BW-1]==0`, otherwise `slot(tok)+BW`.
  - The range is 0..BW.
- **Read mux.** `data_async_o = buf[slot(readpointer_i)]`. The mux is purely combinational and is indexed by the unsynchronized pointer. The far reader samples the payload only after the token it receives shows the slot written, so the selected slot is stable when sampled.
- **Invalid codes.** A non-Johnson `readpointer_i` code is not produced by a legal reader. Under that code the slot decode still returns some value in range, and the block must not hang.

## Timing
- **Reset values:**
  - `writetoken_o` = 0.
  - All synchronizer flops = 0.
  - All buffer slots = 0.
  - `ready_o` = 1.
  - `fill_o` = 0.
  - `data_async_o` = 0 while `readpointer_i` is 0.
- **Token latency.** An accepted beat appears on `writetoken_o` 1 cycle after the accepting edge.
- **Free-up latency.** A far-side pointer step becomes visible in `rp_sync` after 2 `clk_i` edges (3 with the macro). `ready_o` and `fill_o` update in the same cycle `rp_sync` changes.
- **Throughput.** One beat per cycle while not full.
- **Full boundary.**
  - The 8th consecutive beat from empty is accepted.
  - `ready_o` falls in the cycle after that edge and no 9th beat is accepted.
- **Wrap-around.** The token passes from state 2*BW-1 to state 0 with a single-bit change. Slot indexing continues as 7 → 0.
- **Simultaneous write and pointer step when full.** The write is blocked in that cycle. Acceptance resumes in the cycle after the free-up reaches `rp_sync`.
- **Reset mid-operation.**
  - All state clears asynchronously and buffered beats are discarded.
  - The far reader must be reset in the same reset event; this is a system-level requirement.

## Configuration
- **`DC_SRC_SYNC3_EN` defined:** the `readpointer_i` synchronizer has 3 flops, and the free-up latency is 3 cycles.
- **`DC_SRC_SYNC3_EN` undefined:** the synchronizer has 2 flops, and the free-up latency is 2 cycles.
- Nothing else changes with the macro.

## Test plan
- **Reset.** Hold `rst_ni=0`, then release. Required: `writetoken_o=8'h00`, `ready_o=1`, `fill_o=0`.
- **Fill to full.** Drive 8 beats 0xA0..0xA7 back-to-back with `readpointer_i=0`. Required:
  - `writetoken_o` steps 01, 03, …, FF.
  - `ready_o=0` after the 8th beat; a 9th beat is held.
  - `fill_o=8`.
- **Read mux.** With the buffer full, set `readpointer_i=8'h07`. Required: `data_async_o=0xA3` immediately.
- **Free-up latency.** With the buffer full, step `readpointer_i` 00 → 01. Required:
  - `ready_o` rises exactly 2 cycles later (3 with `DC_SRC_SYNC3_EN`).
  - `fill_o=7` in the same cycle.
- **Wrap-around.** Stream 20 beats with a model reader that advances the pointer each cycle. Required:
  - `writetoken_o` passes through 8'h80 and then 8'h00.
  - Each beat is delivered in order with the correct data.
- **Mid-stream reset.** Pulse `rst_ni` low while `fill_o=5`. Required: all outputs at reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/dc_token_src_channel_if.sv
// Handshake / token bundle between the local producer, the writer half of the
// dual-clock token channel, and the far-domain reader.
// slave  : the writer block (dc_token_src_channel)
// master : whoever drives local beats and the far-side read pointer
interface dc_token_src_channel_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = 8
);
  localparam int FILL_WIDTH = $clog2(BUFFER_WIDTH) + 1;

  logic                    valid_i;
  logic                    ready_o;
  logic [DATA_WIDTH-1:0]   data_i;
  logic [BUFFER_WIDTH-1:0] writetoken_o;
  logic [BUFFER_WIDTH-1:0] readpointer_i;
  logic [DATA_WIDTH-1:0]   data_async_o;
  logic [FILL_WIDTH-1:0]   fill_o;

  modport master (
    output valid_i,
    output data_i,
    output readpointer_i,
    input  ready_o,
    input  writetoken_o,
    input  data_async_o,
    input  fill_o
  );

  modport slave (
    input  valid_i,
    input  data_i,
    input  readpointer_i,
    output ready_o,
    output writetoken_o,
    output data_async_o,
    output fill_o
  );
endinterface

// File: rtl/dc_token_src_channel.sv
// Writer half of a token-based dual-clock channel.
// Local beats are stored in a BUFFER_WIDTH-slot register buffer indexed by a
// Johnson-coded write token. The far reader returns a Johnson-coded read
// pointer; it is synchronized here to derive full/fill, and used raw to
// select the slot presented on data_async_o.
// Build option: DC_SRC_SYNC3_EN -> 3-flop read-pointer synchronizer
// (default 2 flops).
module dc_token_src_channel #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  dc_token_src_channel_if.slave  bus
);

  localparam int BW = BUFFER_WIDTH;
  localparam int SW = $clog2(BW);
  localparam int KW = $clog2(2 * BW);
  localparam int FW = $clog2(BW) + 1;

`ifdef DC_SRC_SYNC3_EN
  localparam int SYNC_LEN = 3;
`else
  localparam int SYNC_LEN = 2;
`endif

  // Slot of a Johnson code: ones while MSB is 0, zeros once MSB is 1.
  // Any code (legal or not) maps into 0..BW-1, so the mux can never
  // address outside the buffer.
  function automatic logic [SW-1:0] f_slot(input logic [BW-1:0] tok);
    logic [KW-1:0] ones;
    ones = '0;
    for (int i = 0; i < BW; i++) begin
      ones = ones + KW'(tok[i]);
    end
    if (!tok[BW-1]) begin
      f_slot = SW'(ones);
    end else begin
      f_slot = SW'(KW'(BW) - ones);
    end
  endfunction

  // Position of a Johnson code within its 2*BW-state cycle.
  function automatic logic [KW-1:0] f_kidx(input logic [BW-1:0] tok);
    f_kidx = KW'(f_slot(tok)) + (tok[BW-1] ? KW'(BW) : KW'(0));
  endfunction

  logic [BW-1:0]         r_wtok;
  logic [BW-1:0]         r_sync [SYNC_LEN];
  logic [DATA_WIDTH-1:0] r_buf  [BW];

  logic [BW-1:0]         w_rp_sync;
  logic                  w_full;
  logic                  w_push;
  logic [SW-1:0]         w_wslot;
  logic [SW-1:0]         w_rslot;
  logic [KW-1:0]         w_kw;
  logic [KW-1:0]         w_kr;
  logic [KW:0]           w_fill;

  assign w_rp_sync = r_sync[SYNC_LEN-1];
  assign w_full    = (r_wtok == ~w_rp_sync);
  assign w_push    = bus.valid_i && !w_full;
  assign w_wslot   = f_slot(r_wtok);
  assign w_rslot   = f_slot(bus.readpointer_i);
  assign w_kw      = f_kidx(r_wtok);
  assign w_kr      = f_kidx(w_rp_sync);

  // Occupancy is the modular distance between write and synchronized read
  // positions around the 2*BW-state Johnson cycle.
  always_comb begin
    w_fill = '0;
    if (w_kw >= w_kr) begin
      w_fill = {1'b0, w_kw} - {1'b0, w_kr};
    end else begin
      w_fill = {1'b0, w_kw} + (KW+1)'(2 * BW) - {1'b0, w_kr};
    end
  end

  // Write token advances one Johnson step per accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wtok <= '0;
    end else if (w_push) begin
      r_wtok <= {r_wtok[BW-2:0], ~r_wtok[BW-1]};
    end
  end

  // Read pointer comes from the far clock domain; plain flop chain resync.
  // Johnson coding guarantees only one bit is in flight per step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_LEN; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= bus.readpointer_i;
      for (int i = 1; i < SYNC_LEN; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Payload buffer: accepted beat lands in the slot the write token names.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BW; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_push) begin
      r_buf[w_wslot] <= bus.data_i;
    end
  end

  assign bus.ready_o      = !w_full;
  assign bus.writetoken_o = r_wtok;
  assign bus.fill_o       = w_fill[FW-1:0];
  // Raw pointer on purpose: the far reader only samples a slot after it has
  // seen the token that wrote it, so the selected entry is already stable.
  assign bus.data_async_o = r_buf[w_rslot];

endmodule

// File: tb/tb_dc_token_src_channel.sv
// Bench for dc_token_src_channel: directed phases with randomized traffic,
// checked against a count-based model of the channel (beats written, beats
// read, pointer history for the synchronizer delay).
module tb_dc_token_src_channel;
  localparam int DW = 32;
  localparam int BW = 8;
`ifdef DC_SRC_SYNC3_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  dc_token_src_channel_if #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) bus ();

  dc_token_src_channel #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  int            wcount;
  int            rcount;
  logic [DW-1:0] mem [BW];
  logic [DW-1:0] exp_q [$];
  int            hq [$];
  int            m_fill;
  bit            m_ready;

  // Johnson code for the n-th step, built from its definition: the low k
  // bits set for k < BW, otherwise all bits from (k-BW) upward set.
  function automatic logic [BW-1:0] tok(input int n);
    int k;
    logic [BW-1:0] t;
    k = n % (2 * BW);
    t = '0;
    for (int i = 0; i < BW; i++) begin
      t[i] = (k < BW) ? (i < k) : (i >= k - BW);
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    wcount = 0;
    rcount = 0;
    for (int i = 0; i < BW; i++) mem[i] = '0;
    exp_q.delete();
    hq.delete();
    for (int i = 0; i < SYNC; i++) hq.push_back(0);
    m_fill  = 0;
    m_ready = 1'b1;
  endtask

  // One clock edge: model the accept decision made before the edge, then
  // compare the registered outputs 1 ns after it.
  task automatic tick();
    bit            acc;
    logic [DW-1:0] d;
    acc = bus.valid_i && m_ready;
    d   = bus.data_i;
    @(posedge clk_i);
    #1;
    if (acc) begin
      mem[wcount % BW] = d;
      exp_q.push_back(d);
      wcount++;
    end
    hq.push_back(rcount);
    if (hq.size() > SYNC) void'(hq.pop_front());
    m_fill  = wcount - hq[0];
    m_ready = (m_fill < BW);
    chk("writetoken", bus.writetoken_o, tok(wcount));
    chk("ready",      bus.ready_o, m_ready);
    chk("fill",       bus.fill_o, m_fill);
  endtask

  task automatic set_rp(input int n);
    rcount = n;
    bus.readpointer_i = tok(n);
    #1;
    chk("data_mux", bus.data_async_o, mem[n % BW]);
  endtask

  task automatic read_one();
    logic [DW-1:0] e;
    e = exp_q.pop_front();
    chk("deliver", bus.data_async_o, e);
    set_rp(rcount + 1);
  endtask

  initial begin
    int  n;
    int  target;
    bit  seen80;
    bit  seen00;

    bus.valid_i       = 1'b0;
    bus.data_i        = '0;
    bus.readpointer_i = '0;
    model_reset();

    // Reset
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_token", bus.writetoken_o, 8'h00);
    chk("rst_ready", bus.ready_o, 1'b1);
    chk("rst_fill",  bus.fill_o, 0);
    chk("rst_data",  bus.data_async_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill to full with A0..A7, then attempt a 9th beat
    for (int i = 0; i < 8; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = DW'(32'hA0 + i);
      tick();
    end
    chk("full_token", bus.writetoken_o, 8'hFF);
    chk("full_ready", bus.ready_o, 1'b0);
    chk("full_fill",  bus.fill_o, 8);
    bus.data_i = DW'(32'hA8);
    tick();
    chk("ninth_held", bus.writetoken_o, 8'hFF);

    // Read mux with raw pointer 07 -> slot 3
    set_rp(3);
    chk("mux_a3", bus.data_async_o, 32'hA3);
    set_rp(0);

    // Free-up latency: pointer 00 -> 01 while full, 9th beat still pending
    read_one();
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.ready_o === 1'b1) begin
        n = c;
        break;
      end
    end
    chk("freeup_latency", n, SYNC);
    chk("freeup_fill", bus.fill_o, 7);

    // Randomized stream with a reader that advances whenever a beat exists
    target = wcount + 20;
    seen80 = 1'b0;
    seen00 = 1'b0;
    for (int c = 0; c < 400 && wcount < target; c++) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.data_i  = $urandom;
      tick();
      if (bus.writetoken_o === 8'h80) seen80 = 1'b1;
      if (seen80 && bus.writetoken_o === 8'h00) seen00 = 1'b1;
      if (rcount < wcount) read_one();
    end
    chk("stream_count", (wcount >= target), 1'b1);
    chk("wrap_80_then_00", seen00, 1'b1);
    bus.valid_i = 1'b0;
    for (int c = 0; c < 40 && rcount < wcount; c++) begin
      tick();
      read_one();
    end
    chk("drained", (rcount == wcount), 1'b1);

    // Build occupancy 5, then reset asynchronously between edges
    for (int c = 0; c < 20; c++) begin
      bus.valid_i = ((wcount - rcount) < 5);
      bus.data_i  = $urandom;
      tick();
    end
    bus.valid_i = 1'b0;
    chk("pre_reset_fill", bus.fill_o, 5);
    #2;
    rst_ni            = 1'b0;
    bus.readpointer_i = '0;
    #1;
    chk("async_rst_token", bus.writetoken_o, 8'h00);
    chk("async_rst_ready", bus.ready_o, 1'b1);
    chk("async_rst_fill",  bus.fill_o, 0);
    chk("async_rst_data",  bus.data_async_o, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Recovery traffic after reset
    for (int c = 0; c < 30; c++) begin
      bus.valid_i = $urandom_range(0, 1);
      bus.data_i  = $urandom;
      tick();
      if (rcount < wcount && $urandom_range(0, 1) == 1) read_one();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
